seed_f_iter: RTL and testbench
==============================

Name: seed_f_iter

Overview:
- Parametrised, handshaked successor to the byte-serial SEED F-function. Computes the full 64-bit SEED round function F(C,D,K0,K1) per RFC 4269.
- Uses one shared G-function datapath that is iterated, with LANES S-box byte lanes evaluated per cycle.
- Sits between the round-key scheduler and the Feistel round controller; one F evaluation per handshake.

Parameters:
- LANES, 1, S-box byte lanes evaluated per cycle. Legal values are 1, 2, 4; any other value is an elaboration error.
- BEATS, 4/LANES, derived localparam: cycles per G evaluation. Not user-overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word C/D/K0/K1 valid
- in_ready  out  1  block can accept input
- C  in  32  left half of round input
- D  in  32  right half of round input
- K0  in  32  round subkey 0
- K1  in  32  round subkey 1
- out_valid  out  1  Cn/Dn valid
- out_ready  in  1  consumer accepts result
- Cn  out  32  F output, left
- Dn  out  32  F output, right
- busy  out  1  high in G1/G2/G3

Behaviour:
- States are IDLE, G1, G2, G3, DONE.
- Reset (async, any state): state=IDLE; in_ready=0 during reset, 1 on the first cycle after deassertion. out_valid=0, busy=0, Cn=Dn=0, internal c/d/acc=0, beat=0.
- IDLE: in_ready=1. On in_valid&in_ready: c<=C^K0, d<=(C^K0)^(D^K1), acc<=0, beat<=0, go to G1. Inputs are sampled only on this edge.
- G phase, general rule: the operand is d in G1, c in G2, d in G3.
  - Each cycle, operand bytes [beat*LANES .. beat*LANES+LANES-1] (byte 0 = bits 7:0) pass through SS_i = S-box S1/S2 masked per RFC 4269. Byte index i selects SS0..SS3.
  - acc ^= XOR of the lane results.
  - beat increments, wrapping 0..BEATS-1.
  - On the last beat, g = acc ^ the current lane results.
- G1 last beat: d<=g, c<=c+g (mod 2^32), acc<=0, go to G2.
- G2 last beat: c<=g, d<=d+g (mod 2^32), acc<=0, go to G3.
- G3 last beat: d<=g, c<=c+g (mod 2^32), go to DONE.
- DONE: out_valid=1; Cn=c, Dn=d, both registered. They hold stable until out_valid&out_ready, then go to IDLE with out_valid=0 next cycle. Cn/Dn keep their last value after the handshake.
- Latency: out_valid rises exactly 3*BEATS cycles after the accepting edge, i.e. 3/6/12 cycles for LANES=4/2/1.
- Throughput without the optional feature: one result per 3*BEATS+2 cycles when out_ready is held high.
- in_ready=0 in G1..DONE. in_valid is ignored there and does not need to be held.
- out_ready while out_valid=0 is ignored.
- Additions wrap with no carry out; all arithmetic is 32-bit.
- Reset asserted mid-G or in DONE aborts the operation. No partial result is ever presented.
- busy = state in {G1,G2,G3}.

Optional Feature:
- Macro SEED_F_OVERLAP_EN.
- Defined: in DONE, in_ready=out_ready. If out_valid&out_ready&in_valid occur in the same cycle, the result retires and the new input is loaded in that same edge, going directly to G1. Back-to-back throughput becomes one result per 3*BEATS+1 cycles.
- Undefined: in_ready=0 in DONE, and DONE always returns to IDLE first.

Test Plan:
- LANES=4, reset released; C=0x00000000, D=0x00000000, K0=0x00000000, K1=0x00000000, out_ready=1 -> out_valid exactly 3 cycles after accept. Cn/Dn equal the golden C model, with G(0) from SS tables.
- LANES=1, C=0x01234567, D=0x89ABCDEF, K0=0x7C8F8C7E, K1=0xC737A22C -> out_valid after 12 cycles; Cn/Dn match the golden model. Same vector at LANES=2 -> identical Cn/Dn after 6 cycles.
- Addition wrap check: input drives c+g past 2^32, e.g. C=0xFFFFFFFF, K0=0 -> result matches the mod-2^32 model, with no extra bit.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and Cn/Dn stay stable. in_valid pulses are ignored and in_ready=0. Releasing out_ready gives out_valid=0 next cycle and in_ready=1.
- Reset in G2 (LANES=1, beat 2): reset pulse -> out_valid=0, Cn=Dn=0, busy=0 immediately. A new input after release completes normally with correct output.
- SEED_F_OVERLAP_EN, LANES=4, in_valid and out_ready held high with 4 vectors -> out_valid pulses spaced 4 cycles apart. Every result matches the model.

Source files
------------

// File: rtl/seed_f_iter.sv
// -----------------------------------------------------------------------------
// seed_f_iter -- iterative SEED round function F(C, D, K0, K1) (RFC 4269)
//
// One shared G-function datapath is reused for the three G evaluations of F.
// Each cycle it evaluates LANES S-box byte lanes. One G evaluation takes
// BEATS = 4/LANES cycles, so a full F evaluation takes 3*BEATS cycles.
//
// Parameters:
//   LANES      S-box byte lanes per cycle. Legal values are 1, 2 and 4.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   C/D/K0/K1 valid
//   in_ready   block can accept an input word
//   C, D       round input halves (32 bits each)
//   K0, K1     round subkeys (32 bits each)
//   out_valid  Cn/Dn valid
//   out_ready  consumer accepts the result
//   Cn, Dn     F output halves (32 bits each, registered)
//   busy       high while a G evaluation is in progress
//
// Optional feature (macro SEED_F_OVERLAP_EN):
//   When the macro is defined, the block can retire a result and accept the
//   next input on the same edge. In DONE, in_ready follows out_ready. When the
//   macro is undefined, DONE always returns to IDLE before the next accept.
// -----------------------------------------------------------------------------
module seed_f_iter #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] C,
    input  logic [31:0] D,
    input  logic [31:0] K0,
    input  logic [31:0] K1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Cn,
    output logic [31:0] Dn,
    output logic        busy
);

    localparam int BEATS = 4 / LANES;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("seed_f_iter: LANES must be 1, 2 or 4");
    end

    // Byte masks used to build the SS tables from S1/S2.
    localparam logic [7:0] M0 = 8'hfc;
    localparam logic [7:0] M1 = 8'hf3;
    localparam logic [7:0] M2 = 8'hcf;
    localparam logic [7:0] M3 = 8'h3f;

    // S-box tables. Entry 0 is the most significant byte.
    localparam logic [2047:0] S1_TAB = {
        128'ha985d6d3_541dac25_5d43181e_51fcca63,
        128'h2844209d_e0e2c817_a58f037b_bb13d2ee,
        128'h708c3fa8_32ddf674_ec950b57_5c5bbd01,
        128'h241c7398_10ccf2d9_2ce77283_9bd186c9,
        128'h6050a3eb_0db69e4f_b75ac678_a612afd5,
        128'h61c3b441_527d8d08_1f990019_0453f7e1,
        128'hfd762f27_b08b0eab_a26e934d_697c090a,
        128'hbfeff3c5_8714fe64_de2e4b1a_06216b66,
        128'h02f5928a_0cb37ed0_7a4796e5_2680addf,
        128'ha13037ae_36152238_f4a7454c_81e98497,
        128'h35cbce3c_7111c789_75fbdaf8_945982c4,
        128'hff493967_c0cfd7b8_0f8e4223_916cdba4,
        128'h34f148c2_6f3d2d40_be3ebcc1_aaba4e55,
        128'h3bdc687f_9cd84a56_77a0ed46_b52b65fa,
        128'he3b9b19f_5ef9e6b2_31ea6d5f_e4f0cd88,
        128'h163a58d4_62290733_e81b0579_906a2a9a
    };

    localparam logic [2047:0] S2_TAB = {
        128'h38e82da6_cfdeb3b8_af6055c7_446f6b5b,
        128'hc36233b5_29a0e2a7_d3911106_1cbc364b,
        128'hef886ca8_17c416f4_c245e1d6_3f3d8e98,
        128'h284ef63e_a5f90ddf_d82b667a_272ff172,
        128'h42d441c0_7367ac8b_f7ad801f_ca2caa34,
        128'hd20beee9_5d9418f8_57ae08c5_13cd86b9,
        128'hff7dc131_f58a6ab1_d120d702_22046871,
        128'h07db9d99_61bee659_dd5190dc_9aa3abd0,
        128'h810f471a_e3ec8dbf_967b5ca2_a163234d,
        128'hc89e9c3a_0c2eba6e_9f5af292_f34978cc,
        128'h15fb7075_7f351003_646dc674_d5b4ea09,
        128'h7619fe40_12e0bd05_fa01f02a_5ea95643,
        128'h8514899b_b0e54879_97fc1e82_218c1b5f,
        128'h7754b21d_254f0046_ed5852eb_7edac9fd,
        128'h3095653c_b6e4bb7c_0e503926_32846993,
        128'h37e724a4_cb530a87_d94c838f_ce3b4ab7
    };

    // Entry x sits at byte position 255-x, which is ~x.
    function automatic logic [7:0] s1(input logic [7:0] x);
        s1 = S1_TAB[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] s2(input logic [7:0] x);
        s2 = S2_TAB[{~x, 3'b000} +: 8];
    endfunction

    // SS_idx applied to byte idx of word: S-box followed by the per-byte
    // mask pattern, giving that byte's contribution to the 32-bit G output.
    function automatic logic [31:0] ss_lane(input logic [1:0] idx, input logic [31:0] word);
        logic [7:0] y;
        y = 8'h00;
        case (idx)
            2'd0: begin
                y = s1(word[7:0]);
                ss_lane = {y & M3, y & M2, y & M1, y & M0};
            end
            2'd1: begin
                y = s2(word[15:8]);
                ss_lane = {y & M0, y & M3, y & M2, y & M1};
            end
            2'd2: begin
                y = s1(word[23:16]);
                ss_lane = {y & M1, y & M0, y & M3, y & M2};
            end
            2'd3: begin
                y = s2(word[31:24]);
                ss_lane = {y & M2, y & M1, y & M0, y & M3};
            end
            default: begin
                ss_lane = 32'h0000_0000;
            end
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_G1   = 3'd1,
        ST_G2   = 3'd2,
        ST_G3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_r, state_next_s;
    logic [31:0] c_r, d_r, acc_r;
    logic [31:0] c_next_s, d_next_s, acc_next_s;
    logic [1:0]  beat_r, beat_next_s;
    logic        in_ready_r, out_valid_r, busy_r;
    logic [31:0] cn_r, dn_r;
    logic        load_out_s;
    logic        accept_s;
    logic [31:0] op_s, lane_xor_s, g_s;
    logic [31:0] c_load_s, d_load_s;

    assign c_load_s = C ^ K0;
    assign d_load_s = c_load_s ^ (D ^ K1);

`ifdef SEED_F_OVERLAP_EN
    // In DONE the consumer's ready directly frees the input side.
    assign in_ready = in_ready_r | ((state_r == ST_DONE) & out_ready);
`else
    assign in_ready = in_ready_r;
`endif

    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign Cn        = cn_r;
    assign Dn        = dn_r;

    // Shared G datapath: this beat's lane results folded into the accumulator.
    always_comb begin
        if (state_r == ST_G2) begin
            op_s = c_r;
        end else begin
            op_s = d_r;
        end
        lane_xor_s = 32'h0000_0000;
        for (int l = 0; l < LANES; l++) begin
            lane_xor_s = lane_xor_s ^ ss_lane(2'(int'(beat_r) * LANES + l), op_s);
        end
        g_s = acc_r ^ lane_xor_s;
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next_s = state_r;
        c_next_s     = c_r;
        d_next_s     = d_r;
        acc_next_s   = acc_r;
        beat_next_s  = beat_r;
        load_out_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    c_next_s     = c_load_s;
                    d_next_s     = d_load_s;
                    acc_next_s   = 32'h0000_0000;
                    beat_next_s  = 2'd0;
                    state_next_s = ST_G1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_G1, ST_G2, ST_G3: begin
                if (beat_r == LAST_BEAT) begin
                    acc_next_s  = 32'h0000_0000;
                    beat_next_s = 2'd0;
                    case (state_r)
                        ST_G1: begin
                            d_next_s     = g_s;
                            c_next_s     = c_r + g_s;
                            state_next_s = ST_G2;
                        end
                        ST_G2: begin
                            c_next_s     = g_s;
                            d_next_s     = d_r + g_s;
                            state_next_s = ST_G3;
                        end
                        default: begin
                            d_next_s     = g_s;
                            c_next_s     = c_r + g_s;
                            state_next_s = ST_DONE;
                            load_out_s   = 1'b1;
                        end
                    endcase
                end else begin
                    acc_next_s  = g_s;
                    beat_next_s = beat_r + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
`ifdef SEED_F_OVERLAP_EN
                    if (in_valid) begin
                        c_next_s     = c_load_s;
                        d_next_s     = d_load_s;
                        acc_next_s   = 32'h0000_0000;
                        beat_next_s  = 2'd0;
                        state_next_s = ST_G1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s == ST_G1) || (state_next_s == ST_G2) ||
                           (state_next_s == ST_G3);
        end
    end

    // Working registers and the held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_r    <= 32'h0000_0000;
            d_r    <= 32'h0000_0000;
            acc_r  <= 32'h0000_0000;
            beat_r <= 2'd0;
            cn_r   <= 32'h0000_0000;
            dn_r   <= 32'h0000_0000;
        end else begin
            c_r    <= c_next_s;
            d_r    <= d_next_s;
            acc_r  <= acc_next_s;
            beat_r <= beat_next_s;
            if (load_out_s) begin
                cn_r <= c_next_s;
                dn_r <= d_next_s;
            end else begin
                cn_r <= cn_r;
                dn_r <= dn_r;
            end
        end
    end

endmodule

// File: tb/tb_seed_f_iter.sv
// -----------------------------------------------------------------------------
// tb_seed_f_iter -- self-checking bench for seed_f_iter.
// Three instances (LANES = 4, 2, 1) share clock, reset and data inputs; each
// has its own handshake signals. Expected results come from a behavioural F
// model and are queued on accept, then popped when the result retires.
// -----------------------------------------------------------------------------
module tb_seed_f_iter;

    localparam logic [2047:0] T1 = {
        128'ha985d6d3_541dac25_5d43181e_51fcca63, 128'h2844209d_e0e2c817_a58f037b_bb13d2ee,
        128'h708c3fa8_32ddf674_ec950b57_5c5bbd01, 128'h241c7398_10ccf2d9_2ce77283_9bd186c9,
        128'h6050a3eb_0db69e4f_b75ac678_a612afd5, 128'h61c3b441_527d8d08_1f990019_0453f7e1,
        128'hfd762f27_b08b0eab_a26e934d_697c090a, 128'hbfeff3c5_8714fe64_de2e4b1a_06216b66,
        128'h02f5928a_0cb37ed0_7a4796e5_2680addf, 128'ha13037ae_36152238_f4a7454c_81e98497,
        128'h35cbce3c_7111c789_75fbdaf8_945982c4, 128'hff493967_c0cfd7b8_0f8e4223_916cdba4,
        128'h34f148c2_6f3d2d40_be3ebcc1_aaba4e55, 128'h3bdc687f_9cd84a56_77a0ed46_b52b65fa,
        128'he3b9b19f_5ef9e6b2_31ea6d5f_e4f0cd88, 128'h163a58d4_62290733_e81b0579_906a2a9a
    };
    localparam logic [2047:0] T2 = {
        128'h38e82da6_cfdeb3b8_af6055c7_446f6b5b, 128'hc36233b5_29a0e2a7_d3911106_1cbc364b,
        128'hef886ca8_17c416f4_c245e1d6_3f3d8e98, 128'h284ef63e_a5f90ddf_d82b667a_272ff172,
        128'h42d441c0_7367ac8b_f7ad801f_ca2caa34, 128'hd20beee9_5d9418f8_57ae08c5_13cd86b9,
        128'hff7dc131_f58a6ab1_d120d702_22046871, 128'h07db9d99_61bee659_dd5190dc_9aa3abd0,
        128'h810f471a_e3ec8dbf_967b5ca2_a163234d, 128'hc89e9c3a_0c2eba6e_9f5af292_f34978cc,
        128'h15fb7075_7f351003_646dc674_d5b4ea09, 128'h7619fe40_12e0bd05_fa01f02a_5ea95643,
        128'h8514899b_b0e54879_97fc1e82_218c1b5f, 128'h7754b21d_254f0046_ed5852eb_7edac9fd,
        128'h3095653c_b6e4bb7c_0e503926_32846993, 128'h37e724a4_cb530a87_d94c838f_ce3b4ab7
    };

`ifdef SEED_F_OVERLAP_EN
    localparam int TP_GAP = 4;
`else
    localparam int TP_GAP = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] c_in, d_in, k0_in, k1_in;
    logic [2:0]  iv, ir, ov, ordy, bsy;
    logic [31:0] cn [3];
    logic [31:0] dn [3];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb0[$], sb1[$], sb2[$];

    always #5 clk = ~clk;

    for (genvar gk = 0; gk < 3; gk++) begin : g_dut
        seed_f_iter #(.LANES(gk == 0 ? 4 : (gk == 1 ? 2 : 1))) u_dut (
            .clk(clk), .reset(reset), .in_valid(iv[gk]), .in_ready(ir[gk]),
            .C(c_in), .D(d_in), .K0(k0_in), .K1(k1_in),
            .out_valid(ov[gk]), .out_ready(ordy[gk]),
            .Cn(cn[gk]), .Dn(dn[gk]), .busy(bsy[gk]));
    end

    function automatic logic [7:0] bs1(input logic [7:0] x);
        bs1 = T1[8 * (255 - int'(x)) +: 8];
    endfunction
    function automatic logic [7:0] bs2(input logic [7:0] x);
        bs2 = T2[8 * (255 - int'(x)) +: 8];
    endfunction

    function automatic logic [31:0] g_model(input logic [31:0] x);
        logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
        y0 = bs1(x[7:0]);   y1 = bs2(x[15:8]);
        y2 = bs1(x[23:16]); y3 = bs2(x[31:24]);
        z0 = (y0 & 8'hfc) ^ (y1 & 8'hf3) ^ (y2 & 8'hcf) ^ (y3 & 8'h3f);
        z1 = (y0 & 8'hf3) ^ (y1 & 8'hcf) ^ (y2 & 8'h3f) ^ (y3 & 8'hfc);
        z2 = (y0 & 8'hcf) ^ (y1 & 8'h3f) ^ (y2 & 8'hfc) ^ (y3 & 8'hf3);
        z3 = (y0 & 8'h3f) ^ (y1 & 8'hfc) ^ (y2 & 8'hf3) ^ (y3 & 8'hcf);
        g_model = {z3, z2, z1, z0};
    endfunction

    function automatic logic [63:0] f_model(input logic [31:0] c0, d0, k0, k1);
        logic [31:0] c, d;
        c = c0 ^ k0;
        d = d0 ^ k1;
        d = d ^ c;
        d = g_model(d);
        c = c + d;
        c = g_model(c);
        d = d + c;
        d = g_model(d);
        c = c + d;
        f_model = {c, d};
    endfunction

    function automatic int beats_of(input int k);
        beats_of = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int k, input logic [63:0] v);
        case (k)
            0: sb0.push_back(v);
            1: sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endtask

    // Pops the expected result for instance k and compares it with the output.
    task automatic sb_check(input int k, input string tag);
        logic [63:0] e;
        bit          ok;
        ok = 1'b0;
        e  = 64'h0;
        case (k)
            0: if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
            1: if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
            default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
        endcase
        if (ok) chk($sformatf("%s_l%0d", tag, k), {cn[k], dn[k]}, e);
        else chk($sformatf("%s_sb_empty_l%0d", tag, k), {63'h0, ok}, 64'h1);
    endtask

    task automatic set_data(input logic [31:0] c, d, k0, k1);
        c_in = c; d_in = d; k0_in = k0; k1_in = k1;
    endtask

    // One vector into all three instances; checks latency, busy and result.
    task automatic run_all(input string tag, input logic [31:0] c, d, k0, k1);
        logic [2:0] seen;
        @(posedge clk); #1;
        set_data(c, d, k0, k1);
        for (int k = 0; k < 3; k++) sb_push(k, f_model(c, d, k0, k1));
        iv = 3'b111;
        ordy = 3'b111;
        @(negedge clk);
        chk({tag, "_in_ready"}, {61'h0, ir}, 64'h7);
        @(posedge clk); #1;
        iv = 3'b000;
        seen = 3'b000;
        for (int cyc = 0; cyc < 40 && seen != 3'b111; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_busy"}, {61'h0, bsy}, 64'h7);
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    chk($sformatf("%s_latency_l%0d", tag, k), 64'(cyc), 64'(3 * beats_of(k)));
                    sb_check(k, tag);
                end
            end
        end
        if (seen != 3'b111) chk({tag, "_timeout"}, {61'h0, seen}, 64'h7);
    endtask

    initial begin
        logic [63:0] hold;
        logic [31:0] vec [4][4];
        int          idx, results, last_cyc;
        bit          acc;

        reset = 1'b1;
        iv = 3'b000;
        ordy = 3'b000;
        set_data(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {61'h0, ir}, 64'h0);
        chk("rst_out_valid", {61'h0, ov}, 64'h0);
        chk("rst_busy", {61'h0, bsy}, 64'h0);
        for (int k = 0; k < 3; k++) chk($sformatf("rst_cndn_l%0d", k), {cn[k], dn[k]}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {61'h0, ir}, 64'h7);

        // Main function
        run_all("zero", 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
        run_all("rfc", 32'h01234567, 32'h89ABCDEF, 32'h7C8F8C7E, 32'hC737A22C);
        run_all("wrap", 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000);
        run_all("mix", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000);

        // Backpressure on the LANES=4 instance
        @(posedge clk); #1;
        ordy = 3'b110;
        set_data(32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0);
        sb_push(0, f_model(32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0));
        iv = 3'b001;
        @(posedge clk); #1;
        iv = 3'b000;
        for (int i = 0; i < 20 && !ov[0]; i++) @(negedge clk);
        chk("bp_valid", {63'h0, ov[0]}, 64'h1);
        hold = {cn[0], dn[0]};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            iv[0] = (i % 2 == 0);
            set_data(32'h11111111 * i, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk("bp_hold_valid", {63'h0, ov[0]}, 64'h1);
            chk("bp_hold_data", {cn[0], dn[0]}, hold);
            chk("bp_in_ready", {63'h0, ir[0]}, 64'h0);
        end
        @(posedge clk); #1;
        iv = 3'b000;
        ordy = 3'b111;
        @(negedge clk);
        sb_check(0, "bp_result");
        @(negedge clk);
        chk("bp_release_valid", {63'h0, ov[0]}, 64'h0);
        chk("bp_release_ready", {63'h0, ir[0]}, 64'h1);
        chk("bp_keep_data", {cn[0], dn[0]}, hold);

        // Reset in G2, beat 2, on the LANES=1 instance
        @(posedge clk); #1;
        set_data(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01020304, 32'h05060708);
        sb_push(2, f_model(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01020304, 32'h05060708));
        iv = 3'b100;
        @(posedge clk); #1;
        iv = 3'b000;
        for (int cyc = 0; cyc < 7; cyc++) @(negedge clk);
        chk("g2_busy", {63'h0, bsy[2]}, 64'h1);
        chk("g2_not_valid", {63'h0, ov[2]}, 64'h0);
        reset = 1'b1;
        #1;
        chk("abort_valid", {63'h0, ov[2]}, 64'h0);
        chk("abort_busy", {63'h0, bsy[2]}, 64'h0);
        chk("abort_cndn", {cn[2], dn[2]}, 64'h0);
        chk("abort_in_ready", {63'h0, ir[2]}, 64'h0);
        sb2.delete();
        #2;
        reset = 1'b0;
        run_all("after_abort", 32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0);

        // Back-to-back throughput on the LANES=4 instance
        vec[0] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        vec[1] = '{32'hCAFEBABE, 32'h8BADF00D, 32'hFEEDFACE, 32'h0D15EA5E};
        vec[2] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vec[3] = '{32'h31415926, 32'h53589793, 32'h23846264, 32'h33832795};
        @(posedge clk); #1;
        idx = 0;
        results = 0;
        last_cyc = 0;
        set_data(vec[0][0], vec[0][1], vec[0][2], vec[0][3]);
        iv = 3'b001;
        ordy = 3'b111;
        for (int cyc = 0; cyc < 80 && results < 4; cyc++) begin
            @(negedge clk);
            acc = 1'b0;
            if (ov[0]) begin
                sb_check(0, "tp_result");
                if (results > 0) chk("tp_spacing", 64'(cyc - last_cyc), 64'(TP_GAP));
                last_cyc = cyc;
                results++;
            end
            if (iv[0] && ir[0]) begin
                sb_push(0, f_model(c_in, d_in, k0_in, k1_in));
                idx++;
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (idx < 4) set_data(vec[idx][0], vec[idx][1], vec[idx][2], vec[idx][3]);
                else iv = 3'b000;
            end
        end
        if (results < 4) chk("tp_timeout", 64'(results), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
